// File: rtl/apb_ram.sv
// -----------------------------------------------------------------------------
// apb_ram
//   APB3 completer in front of a small word-addressed RAM of DEPTH words.
//   Every transfer takes three cycles: setup, one wait cycle with pready low,
//   then the access cycle with pready high. Out-of-range addresses complete
//   with pslverr and never touch the RAM. All outputs are registered.
//
// Ports
//   pclk      in   1       clock, rising edge
//   preset_n  in   1       asynchronous reset, active-high (1 = in reset)
//   psel      in   1       completer select
//   penable   in   1       access-phase strobe
//   pwrite    in   1       1 = write, 0 = read
//   paddr     in   ADDR_W  word address
//   pwdata    in   DATA_W  write data
//   prdata    out  DATA_W  read data, valid while pready=1 on a read
//   pready    out  1       transfer complete
//   pslverr   out  1       error, valid while pready=1
// -----------------------------------------------------------------------------
module apb_ram #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic              addr_err;
    logic [IDX_W-1:0]  idx;
    logic              wr_en;

    // Range check on the full paddr so aliased upper bits are flagged as
    // errors rather than wrapping onto a low word.
    assign addr_err = (paddr >= DEPTH_A);
    assign idx      = paddr[IDX_W-1:0];

    // Next-state, output and write-enable decode
    always_comb begin
        state_d   = state_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        wr_en     = 1'b0;

        case (state_q)
            IDLE: begin
                // An X on psel fails this test and keeps us idle.
                if (psel && !penable) begin
                    state_d = SETUP;
                end
            end

            SETUP: begin
                if (psel) begin
                    state_d   = ACCESS;
                    pready_d  = 1'b1;
                    pslverr_d = addr_err;
                    if (!pwrite) begin
                        prdata_d = addr_err ? '0 : mem_q[idx];
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            ACCESS: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                // A completing transfer has penable=1 on this edge, so the
                // next setup phase (psel=1, penable=0) is picked up from IDLE
                // one cycle later; that keeps every transfer at three cycles.
                state_d   = IDLE;
                if (psel && penable) begin
                    // pslverr_q still holds the range result from SETUP.
                    wr_en = pwrite && !pslverr_q;
                end
                // Otherwise the requester dropped psel/penable mid-access:
                // the transfer is abandoned without a write.
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM next-value: only the addressed word changes on a committed write
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[idx] = pwdata;
        end
    end

    // State, output and RAM registers
    always_ff @(posedge pclk or posedge preset_n) begin
        if (preset_n) begin
            state_q   <= IDLE;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            mem_q     <= mem_d;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_ram.sv
// -----------------------------------------------------------------------------
// tb_apb_ram
//   Self-checking bench for apb_ram. A plain array of words stands in for the
//   RAM; each transfer's expected pslverr/prdata is derived from that array
//   and the address range rule.
// -----------------------------------------------------------------------------
module tb_apb_ram;

    localparam int DEPTH = 32;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ref_mem [DEPTH];

    always #5 pclk = ~pclk;

    apb_ram #(
        .ADDR_W(32),
        .DATA_W(32),
        .DEPTH (DEPTH)
    ) dut (
        .pclk    (pclk),
        .preset_n(preset_n),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic ref_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    task automatic idle(input int n);
        psel    = 1'b0;
        penable = 1'b0;
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // One APB transfer. Called #1 after a rising edge; returns #1 after the
    // completing edge with the bus idle, so consecutive calls are back-to-back.
    task automatic xfer(input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input string tag);
        logic        err_exp;
        logic [31:0] rd_exp;
        int          waits;
        err_exp = (addr >= 32'(DEPTH));
        rd_exp  = err_exp ? 32'h0 : ref_mem[addr[4:0]];

        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(posedge pclk); #1;
        check({tag, "_wait"}, {31'b0, pready}, 32'h0);
        penable = 1'b1;

        waits = 0;
        do begin
            @(posedge pclk); #1;
            waits++;
        end while (!pready && waits < 4);
        check({tag, "_lat"}, 32'(waits), 32'd1);
        check({tag, "_err"}, {31'b0, pslverr}, {31'b0, err_exp});
        if (!wr) check({tag, "_rdata"}, prdata, rd_exp);

        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        check({tag, "_done"}, {30'b0, pready, pslverr}, 32'h0);

        if (wr && !err_exp) ref_mem[addr[4:0]] = data;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        psel     = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = '0;
        pwdata   = '0;
        preset_n = 1'b1;
        ref_clear();
        repeat (2) @(posedge pclk);
        #1;
        check("rst_prdata",  prdata, 32'h0);
        check("rst_pready",  {31'b0, pready}, 32'h0);
        check("rst_pslverr", {31'b0, pslverr}, 32'h0);
        preset_n = 1'b0;
        idle(1);

        xfer(1'b0, 32'd7, 32'h0, "rd7_rst");

        xfer(1'b1, 32'd5, 32'hDEADBEEF, "wr5");
        xfer(1'b0, 32'd5, 32'h0, "rd5");

        xfer(1'b1, 32'd40, 32'h12345678, "wr40");
        xfer(1'b0, 32'd40, 32'h0, "rd40");
        xfer(1'b0, 32'd8, 32'h0, "rd8");

        // Upper address bits alias word 5 if truncated
        xfer(1'b1, 32'h0000_0105, 32'h0BAD_0BAD, "wr_hi");
        xfer(1'b1, 32'h8000_0005, 32'h0BAD_0BAD, "wr_top");
        xfer(1'b0, 32'd5, 32'h0, "rd5_hi");
        idle(2);

        xfer(1'b1, 32'd0,  32'h1111_0000, "b2b_wr0");
        xfer(1'b1, 32'd1,  32'h2222_0001, "b2b_wr1");
        xfer(1'b1, 32'd31, 32'h3333_001F, "b2b_wr31");
        xfer(1'b0, 32'd31, 32'h0, "b2b_rd31");
        xfer(1'b0, 32'd0,  32'h0, "b2b_rd0");
        idle(1);

        // Reset during the wait cycle of a write to word 3
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'd3;
        pwdata  = 32'hA5A5A5A5;
        @(posedge pclk); #1;
        penable = 1'b1;
        #2;
        preset_n = 1'b1;
        #1;
        check("arst_prdata", prdata, 32'h0);
        check("arst_pready", {31'b0, pready}, 32'h0);
        psel    = 1'b0;
        penable = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        preset_n = 1'b0;
        ref_clear();
        idle(1);
        xfer(1'b0, 32'd3, 32'h0, "rd3_arst");
        xfer(1'b0, 32'd0, 32'h0, "rd0_arst");

        for (int i = 0; i < 30; i++) begin
            logic        wr;
            logic [31:0] addr;
            logic [31:0] data;
            wr   = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 39));
            data = $urandom;
            xfer(wr, addr, data, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 2) == 0) idle(1);
        end

        // Read back every word once so random writes are all observed
        for (int a = 0; a < DEPTH; a++) begin
            xfer(1'b0, 32'(a), 32'h0, $sformatf("sweep%0d", a));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
